memi_arbiter: RTL

- Shares one memory-interface (memi) bus between NR_MASTERS debug requesters, e.g. core debug port channel 0 and a second debug or trace master.
- Arbitrates round-robin and holds the grant for a whole transaction.
- Drives slave-side memi signals stable for at least 2 clocks; the APB-like slaves require this.
- Returns read data and a completion pulse to the granted master only.

---
 rtl/memi_arb_pkg.sv | 14 +
 rtl/memi_arbiter_if.sv | 24 ++
 rtl/memi_rr_pick.sv | 27 ++
 rtl/memi_arbiter.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/memi_arb_pkg.sv
// Shared types and constants for the memi bus arbiter.
package memi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ADDR    = 2'd1,
        WAIT    = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

    // Fill bit for m_rdata when a transaction is aborted by the watchdog.
    localparam logic ARB_ERR_RDATA_FILL = 1'b1;

endpackage

// File: rtl/memi_arbiter_if.sv
// Slave-side memi bus: the arbiter drives it through the master modport.
interface memi_arbiter_if #(
    parameter int NR_SLAVES   = 1,
    parameter int ADDR_WIDTH  = 5,
    parameter int WDATA_WIDTH = 32,
    parameter int RDATA_WIDTH = 32
);
    logic [NR_SLAVES-1:0]   memi_sel;
    logic [ADDR_WIDTH-1:0]  memi_addr;
    logic                   memi_wr_rd;
    logic [WDATA_WIDTH-1:0] memi_wdata;
    logic [RDATA_WIDTH-1:0] memi_rdata;
    logic                   memi_ready;

    modport master (
        output memi_sel, memi_addr, memi_wr_rd, memi_wdata,
        input  memi_rdata, memi_ready
    );

    modport slave (
        input  memi_sel, memi_addr, memi_wr_rd, memi_wdata,
        output memi_rdata, memi_ready
    );
endinterface

// File: rtl/memi_rr_pick.sv
// Combinational round-robin picker: first requester after ptr, wrapping.
module memi_rr_pick #(
    parameter int NR_MASTERS = 2,
    parameter int PTR_W      = (NR_MASTERS > 1) ? $clog2(NR_MASTERS) : 1
) (
    input  logic [NR_MASTERS-1:0] req,
    input  logic [PTR_W-1:0]      ptr,
    output logic [NR_MASTERS-1:0] winner
);
    import memi_arb_pkg::*;

    logic found;
    int   idx;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 1; k <= NR_MASTERS; k++) begin
            idx = (int'(ptr) + k) % NR_MASTERS;
            if (!found && req[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end
endmodule

// File: rtl/memi_arbiter.sv
// Round-robin arbiter sharing one memi bus between NR_MASTERS requesters.
// Optional WAIT watchdog enabled by defining MEMI_ARB_TIMEOUT_EN.
module memi_arbiter
    import memi_arb_pkg::*;
#(
    parameter int NR_MASTERS       = 2,
    parameter int MEMI_NR_SLAVES   = 1,
    parameter int MEMI_ADDR_WIDTH  = 5,
    parameter int MEMI_WDATA_WIDTH = 32,
    parameter int MEMI_RDATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES   = 255
) (
    input  logic                                   memi_clk,
    input  logic                                   memi_rst,
    input  logic [NR_MASTERS*MEMI_NR_SLAVES-1:0]   m_sel,
    input  logic [NR_MASTERS*MEMI_ADDR_WIDTH-1:0]  m_addr,
    input  logic [NR_MASTERS-1:0]                  m_wr_rd,
    input  logic [NR_MASTERS*MEMI_WDATA_WIDTH-1:0] m_wdata,
    output logic [MEMI_RDATA_WIDTH-1:0]            m_rdata,
    output logic [NR_MASTERS-1:0]                  m_ready,
    output logic [NR_MASTERS-1:0]                  m_err,
    memi_arbiter_if.master                         memi,
    output logic [NR_MASTERS-1:0]                  grant,
    output logic                                   busy
);
    localparam int PTR_W = (NR_MASTERS > 1) ? $clog2(NR_MASTERS) : 1;

    arb_state_t            state;
    logic [PTR_W-1:0]      ptr;
    logic [PTR_W-1:0]      widx;
    logic [NR_MASTERS-1:0] req;
    logic [NR_MASTERS-1:0] win;

    always_comb begin
        for (int i = 0; i < NR_MASTERS; i++)
            req[i] = |m_sel[i*MEMI_NR_SLAVES +: MEMI_NR_SLAVES];
    end

    memi_rr_pick #(.NR_MASTERS(NR_MASTERS), .PTR_W(PTR_W)) u_pick (
        .req    (req),
        .ptr    (ptr),
        .winner (win)
    );

    always_comb begin
        widx = '0;
        for (int i = 0; i < NR_MASTERS; i++)
            if (win[i]) widx = PTR_W'(i);
    end

    assign busy = (state != IDLE);

`ifdef MEMI_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt;
`else
    assign m_err = '0;
`endif

    always_ff @(posedge memi_clk or posedge memi_rst) begin
        if (memi_rst) begin
            state           <= IDLE;
            ptr             <= PTR_W'(NR_MASTERS - 1);
            grant           <= '0;
            m_ready         <= '0;
            m_rdata         <= '0;
            memi.memi_sel   <= '0;
            memi.memi_addr  <= '0;
            memi.memi_wr_rd <= 1'b0;
            memi.memi_wdata <= '0;
`ifdef MEMI_ARB_TIMEOUT_EN
            m_err           <= '0;
            cnt             <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        state           <= ADDR;
                        grant           <= win;
                        ptr             <= widx;
                        memi.memi_sel   <= m_sel[int'(widx)*MEMI_NR_SLAVES +: MEMI_NR_SLAVES];
                        memi.memi_addr  <= m_addr[int'(widx)*MEMI_ADDR_WIDTH +: MEMI_ADDR_WIDTH];
                        memi.memi_wr_rd <= m_wr_rd[widx];
                        memi.memi_wdata <= m_wdata[int'(widx)*MEMI_WDATA_WIDTH +: MEMI_WDATA_WIDTH];
`ifdef MEMI_ARB_TIMEOUT_EN
                        cnt             <= '0;
`endif
                    end
                end
                // ADDR ignores memi_ready so the slave sees sel for at least two clocks.
                ADDR: state <= WAIT;
                WAIT: begin
                    if (memi.memi_ready) begin
                        state           <= RELEASE;
                        m_ready         <= grant;
                        m_rdata         <= memi.memi_wr_rd ? '0 : memi.memi_rdata;
                        memi.memi_sel   <= '0;
                        memi.memi_addr  <= '0;
                        memi.memi_wr_rd <= 1'b0;
                        memi.memi_wdata <= '0;
                    end
`ifdef MEMI_ARB_TIMEOUT_EN
                    else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state           <= RELEASE;
                        m_ready         <= grant;
                        m_err           <= grant;
                        m_rdata         <= {MEMI_RDATA_WIDTH{ARB_ERR_RDATA_FILL}};
                        memi.memi_sel   <= '0;
                        memi.memi_addr  <= '0;
                        memi.memi_wr_rd <= 1'b0;
                        memi.memi_wdata <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                // One idle gap keeps the finishing master's stale request from winning again.
                RELEASE: begin
                    state   <= IDLE;
                    m_ready <= '0;
                    m_rdata <= '0;
                    grant   <= '0;
`ifdef MEMI_ARB_TIMEOUT_EN
                    m_err   <= '0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    generate
        if (MEMI_NR_SLAVES > 1) begin : g_sel_chk
            for (genvar g = 0; g < NR_MASTERS; g++) begin : g_m
                a_sel_onehot: assert property (@(posedge memi_clk) disable iff (memi_rst)
                    $onehot0(m_sel[g*MEMI_NR_SLAVES +: MEMI_NR_SLAVES]));
            end
        end
    endgenerate
endmodule
